seg7_scan_decoder: RTL and testbench



---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/seg7_scan_decoder_if.sv | 24 ++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display path:
// segment codes, digit-select encodings, decoder FSM states.
package seg7_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned BCD_W = 12;

   // Segment codes {g,f,e,d,c,b,a}, active-high
   localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

   // One-hot digit selects; all-zero is the blanking gap
   localparam logic [SEL_W-1:0] DIG_NONE     = 3'b000;
   localparam logic [SEL_W-1:0] DIG_UNITS    = 3'b001;
   localparam logic [SEL_W-1:0] DIG_TENS     = 3'b010;
   localparam logic [SEL_W-1:0] DIG_HUNDREDS = 3'b100;

   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      CAP0 = 2'd1,
      CAP1 = 2'd2,
      CAP2 = 2'd3
   } state_t;

   function automatic logic is_onehot3(input logic [SEL_W-1:0] s);
      return (s == DIG_UNITS) || (s == DIG_TENS) || (s == DIG_HUNDREDS);
   endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display-bus monitor interface: scanned segment/select inputs and
// recovered frame outputs.
interface seg7_scan_decoder_if;
   import seg7_pkg::*;

   logic [SEG_W-1:0] seg_in;
   logic [SEL_W-1:0] digit_sel_in;
   logic [BCD_W-1:0] bcd_out;
   logic             frame_valid;
   logic             frame_err;
   logic             sync_lost;

   // Side driving the display bus and consuming recovered frames
   modport master (
      output seg_in, digit_sel_in,
      input  bcd_out, frame_valid, frame_err, sync_lost
   );

   // Decoder side
   modport slave (
      input  seg_in, digit_sel_in,
      output bcd_out, frame_valid, frame_err, sync_lost
   );
endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD digit decoder.
module seg7_to_bcd
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] i_seg,
   output logic             o_valid,
   output logic [3:0]       o_digit
);

   // Map legal digit patterns; anything else is flagged invalid
   always_comb begin
      o_valid = 1'b1;
      o_digit = BCD_INVALID;
      case (i_seg)
         SEG_0:   o_digit = 4'd0;
         SEG_1:   o_digit = 4'd1;
         SEG_2:   o_digit = 4'd2;
         SEG_3:   o_digit = 4'd3;
         SEG_4:   o_digit = 4'd4;
         SEG_5:   o_digit = 4'd5;
         SEG_6:   o_digit = 4'd6;
         SEG_7:   o_digit = 4'd7;
         SEG_8:   o_digit = 4'd8;
         SEG_9:   o_digit = 4'd9;
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers 3-digit BCD frames from a scanned 7-segment display bus.
// Synchronizes the bus, filters short dwells, and tracks the
// units -> tens -> hundreds scan order, re-syncing on any violation.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic               clk,
   input  logic               rst,
   seg7_scan_decoder_if.slave bus
);

   localparam int unsigned S_W    = SEL_W + SEG_W;
   localparam logic [7:0]  ACC_AT = 8'(STABLE_CYCLES - 2);

   logic [S_W-1:0]   r_sync [SYNC_STAGES];
   logic [S_W-1:0]   r_prev;
   logic [7:0]       r_cnt;
   state_t           r_state;
   logic             r_acc;
   logic             r_err_acc;
   logic [2:0][3:0]  r_dig;
   logic [BCD_W-1:0] r_bcd;
   logic             r_frame_valid;
   logic             r_frame_err;
   logic             r_sync_lost;

   logic [S_W-1:0]   w_s;
   logic [SEL_W-1:0] w_sel;
   logic [SEG_W-1:0] w_seg;
   logic             w_same;
   logic             w_accept;
   logic             w_sel_bad;
   logic             w_seg_ok;
   logic [3:0]       w_digit;
   logic [SEL_W-1:0] w_exp_sel;
   logic [SEL_W-1:0] w_next_sel;
   state_t           w_next_state;

   assign w_s       = r_sync[SYNC_STAGES-1];
   assign w_sel     = w_s[S_W-1:SEG_W];
   assign w_seg     = w_s[SEG_W-1:0];
   assign w_same    = (w_s == r_prev);
   // Fires once per dwell: the sample that brings the run to STABLE_CYCLES
   assign w_accept  = w_same && (r_cnt == ACC_AT) && is_onehot3(w_sel);
   assign w_sel_bad = (w_sel != DIG_NONE) && !is_onehot3(w_sel);

   seg7_to_bcd u_to_bcd (
      .i_seg   (w_seg),
      .o_valid (w_seg_ok),
      .o_digit (w_digit)
   );

   // Expected select for the current capture state and the one that follows
   always_comb begin
      w_exp_sel    = DIG_UNITS;
      w_next_sel   = DIG_TENS;
      w_next_state = CAP1;
      case (r_state)
         CAP1: begin
            w_exp_sel    = DIG_TENS;
            w_next_sel   = DIG_HUNDREDS;
            w_next_state = CAP2;
         end
         CAP2: begin
            w_exp_sel    = DIG_HUNDREDS;
            w_next_sel   = DIG_UNITS;
            w_next_state = CAP0;
         end
         default: ;
      endcase
   end

   // Input synchronizer chain on {sel, seg}
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= {bus.digit_sel_in, bus.seg_in};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   // Stability counter: saturating run length of identical samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_prev <= w_s;
         if (!w_same)
            r_cnt <= '0;
         else if (r_cnt != '1)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   // Scan-order FSM with digit capture and registered frame outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= SYNC;
         r_acc         <= 1'b0;
         r_err_acc     <= 1'b0;
         r_dig         <= '0;
         r_bcd         <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_sync_lost   <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_sync_lost   <= 1'b0;
         case (r_state)
            SYNC: begin
               if (w_sel == DIG_UNITS) begin
                  r_state   <= CAP0;
                  r_dig     <= '0;
                  r_err_acc <= 1'b0;
                  r_acc     <= 1'b0;
                  // With a short threshold the units dwell can complete on
                  // the very cycle SYNC re-enters; keep that digit.
                  if (w_accept) begin
                     r_dig[0]  <= w_digit;
                     r_err_acc <= !w_seg_ok;
                     r_acc     <= 1'b1;
                  end
               end
            end
            default: begin
               if (w_sel_bad) begin
                  r_sync_lost <= 1'b1;
                  r_state     <= SYNC;
                  r_acc       <= 1'b0;
               end else if (!r_acc) begin
                  // Before acceptance only the blanking gap or the own select is legal
                  if (w_sel != DIG_NONE && w_sel != w_exp_sel) begin
                     r_sync_lost <= 1'b1;
                     r_state     <= SYNC;
                  end else if (w_accept) begin
                     case (r_state)
                        CAP0:    r_dig[0] <= w_digit;
                        CAP1:    r_dig[1] <= w_digit;
                        default: r_dig[2] <= w_digit;
                     endcase
                     if (!w_seg_ok) r_err_acc <= 1'b1;
                     r_acc <= 1'b1;
                  end
               end else if (w_sel == w_next_sel) begin
                  r_acc   <= 1'b0;
                  r_state <= w_next_state;
                  if (r_state == CAP2) begin
                     r_bcd         <= r_dig;
                     r_frame_valid <= 1'b1;
                     r_frame_err   <= r_err_acc;
                     r_dig         <= '0;
                     r_err_acc     <= 1'b0;
                  end
               end else if (w_sel != DIG_NONE && w_sel != w_exp_sel) begin
                  r_sync_lost <= 1'b1;
                  r_state     <= SYNC;
                  r_acc       <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.bcd_out     = r_bcd;
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_err   = r_frame_err;
   assign bus.sync_lost   = r_sync_lost;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: table of clean/erroneous frames
// plus hand sequences for glitch, latency, order loss and mid-frame reset.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   logic clk;
   logic rst;

   seg7_scan_decoder_if u_if ();

   seg7_scan_decoder #(
      .STABLE_CYCLES (4),
      .SYNC_STAGES   (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  u;
      logic [6:0]  t;
      logic [6:0]  h;
      logic [11:0] exp_bcd;
      logic        exp_err;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_fv     = 0;
   int          n_sl     = 0;
   logic [11:0] last_bcd = '0;
   logic        last_err = 1'b0;

   // Pulse monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (u_if.frame_valid) begin
         n_fv++;
         last_bcd = u_if.bcd_out;
         last_err = u_if.frame_err;
      end
      if (u_if.sync_lost) n_sl++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic dwell(input logic [2:0] sel, input logic [6:0] seg, input int n);
      u_if.digit_sel_in = sel;
      u_if.seg_in       = seg;
      repeat (n) @(negedge clk);
   endtask

   // Units dwell is left to the caller: it also closes the previous frame
   task automatic rest_of_frame(input logic [6:0] t, input logic [6:0] h);
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_TENS, t, 8);
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_HUNDREDS, h, 8);
   endtask

   task automatic check_frame(input string name, input logic [11:0] eb, input logic ee,
                              input int fv0, input int sl0);
      chk({name, "_pulses"}, 32'(n_fv - fv0), 32'd1);
      chk({name, "_bcd"}, 32'(last_bcd), 32'(eb));
      chk({name, "_err"}, 32'(last_err), 32'(ee));
      chk({name, "_sync_lost"}, 32'(n_sl - sl0), 32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      int fv0;
      int sl0;
      int lat;

      vecs[0] = '{u: SEG_3, t: SEG_2, h: SEG_1, exp_bcd: 12'h123, exp_err: 1'b0};
      vecs[1] = '{u: SEG_6, t: SEG_5, h: SEG_4, exp_bcd: 12'h456, exp_err: 1'b0};
      vecs[2] = '{u: SEG_6, t: SEG_5, h: SEG_4, exp_bcd: 12'h456, exp_err: 1'b0};
      vecs[3] = '{u: SEG_0, t: SEG_9, h: SEG_8, exp_bcd: 12'h890, exp_err: 1'b0};
      vecs[4] = '{u: 7'h7E, t: SEG_2, h: SEG_1, exp_bcd: 12'h12F, exp_err: 1'b1};
      vecs[5] = '{u: SEG_7, t: SEG_6, h: 7'h00, exp_bcd: 12'hF67, exp_err: 1'b1};

      rst = 1'b1;
      u_if.digit_sel_in = '0;
      u_if.seg_in       = '0;
      repeat (3) @(negedge clk);
      chk("reset_bcd", 32'(u_if.bcd_out), 32'h0);
      chk("reset_fv", 32'(u_if.frame_valid), 32'h0);
      chk("reset_err", 32'(u_if.frame_err), 32'h0);
      chk("reset_sl", 32'(u_if.sync_lost), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back frames; each units dwell publishes the previous frame
      fv0 = n_fv;
      sl0 = n_sl;
      for (int i = 0; i <= 6; i++) begin
         dwell(DIG_UNITS, (i < 6) ? vecs[i].u : SEG_0, 8);
         if (i > 0) begin
            check_frame($sformatf("vec%0d", i - 1), vecs[i-1].exp_bcd, vecs[i-1].exp_err, fv0, sl0);
         end else begin
            chk("first_units_no_pulse", 32'(n_fv - fv0), 32'd0);
         end
         fv0 = n_fv;
         sl0 = n_sl;
         if (i < 6) rest_of_frame(vecs[i].t, vecs[i].h);
      end

      // Glitchy tens dwell (units 0 already captured above)
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_TENS, SEG_2, 2);
      dwell(DIG_TENS, SEG_1, 8);
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_HUNDREDS, SEG_7, 8);
      // Latency from raw 100->001 to frame_valid
      u_if.digit_sel_in = DIG_UNITS;
      u_if.seg_in       = SEG_4;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (u_if.frame_valid && lat == 0) lat = k;
      end
      chk("latency", 32'(lat), 32'd3);
      @(negedge clk);
      check_frame("glitch", 12'h710, 1'b0, fv0, sl0);

      // Order violation 001 -> 100
      fv0 = n_fv;
      sl0 = n_sl;
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_HUNDREDS, SEG_1, 8);
      chk("order_sl", 32'(n_sl - sl0), 32'd1);
      chk("order_no_pulse", 32'(n_fv - fv0), 32'd0);
      chk("order_bcd_hold", 32'(u_if.bcd_out), 32'h710);

      // Recovery frame
      fv0 = n_fv;
      sl0 = n_sl;
      dwell(DIG_UNITS, SEG_9, 8);
      rest_of_frame(SEG_8, SEG_2);
      dwell(DIG_UNITS, SEG_5, 8);
      check_frame("recover", 12'h289, 1'b0, fv0, sl0);

      // Non-one-hot select during CAP1
      fv0 = n_fv;
      sl0 = n_sl;
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_TENS, SEG_6, 8);
      dwell(3'b011, SEG_6, 4);
      chk("nonhot_sl", 32'(n_sl - sl0), 32'd1);
      chk("nonhot_no_pulse", 32'(n_fv - fv0), 32'd0);
      chk("nonhot_bcd_hold", 32'(u_if.bcd_out), 32'h289);
      dwell(DIG_NONE, 7'h00, 2);

      // Reset in the middle of the hundreds dwell
      fv0 = n_fv;
      dwell(DIG_UNITS, SEG_1, 8);
      rest_of_frame(SEG_2, SEG_3);
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_UNITS, SEG_1, 8);
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_TENS, SEG_2, 8);
      dwell(DIG_NONE, 7'h00, 2);
      dwell(DIG_HUNDREDS, SEG_3, 4);
      chk("pre_reset_pulse", 32'(n_fv - fv0), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_bcd", 32'(u_if.bcd_out), 32'h0);
      chk("midrst_fv", 32'(u_if.frame_valid), 32'h0);
      chk("midrst_err", 32'(u_if.frame_err), 32'h0);
      chk("midrst_sl", 32'(u_if.sync_lost), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      fv0 = n_fv;
      sl0 = n_sl;
      dwell(DIG_HUNDREDS, SEG_3, 8);
      dwell(DIG_UNITS, SEG_4, 8);
      chk("postrst_no_pulse", 32'(n_fv - fv0), 32'd0);
      chk("postrst_bcd", 32'(u_if.bcd_out), 32'h0);
      rest_of_frame(SEG_5, SEG_6);
      dwell(DIG_UNITS, SEG_0, 8);
      check_frame("postrst", 12'h654, 1'b0, fv0, sl0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
